// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 16-bit ALU: decodes instructions, reads the 8x16
// register file, holds operands for ALU_LAT cycles, then writes the result back.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 2,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_code,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_overflow,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              ovf_sticky,
  input  logic              ovf_clear,
  output logic              illegal_sticky,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [4:0]        alu_code_q, alu_code_d;
  logic [2:0]        rd_q, rd_d;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  logic              wb_valid_q, wb_valid_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              ovf_sticky_q, ovf_sticky_d;
  logic              illegal_sticky_q, illegal_sticky_d;
  logic              ovf_set;
  logic              code_legal;
  logic              code_ovf;
  logic              unused_instr_bit;

  assign unused_instr_bit = instr[0];

  assign code_legal = alu_code_q inside {[5'd0:5'd5], 5'd8, 5'd9, 5'd10, 5'd12,
                                         [5'd16:5'd19], [5'd24:5'd29]};
  assign code_ovf   = alu_code_q inside {5'd0, 5'd2, 5'd4, 5'd5};

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    alu_a_d          = alu_a_q;
    alu_b_d          = alu_b_q;
    alu_code_d       = alu_code_q;
    rd_d             = rd_q;
    regs_d           = regs_q;
    wb_valid_d       = 1'b0;
    wb_addr_d        = wb_addr_q;
    wb_data_d        = wb_data_q;
    illegal_sticky_d = illegal_sticky_q;
    ovf_set          = 1'b0;
    case (state_q)
      IDLE: begin
        // Operands come from regs_q, so a same-edge cfg write is not visible here
        if (instr_valid) begin
          alu_code_d = instr[15:11];
          rd_d       = instr[10:8];
          alu_a_d    = regs_q[instr[7:5]];
          alu_b_d    = instr[1] ? {{(DATA_W-3){1'b0}}, instr[4:2]} : regs_q[instr[4:2]];
          cnt_d      = 4'(ALU_LAT - 1);
          state_d    = EXEC;
        end
        if (cfg_we) begin
          regs_d[cfg_addr] = cfg_wdata;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = WB;
          if (code_legal) begin
            regs_d[rd_q] = alu_c;
            wb_valid_d   = 1'b1;
            wb_addr_d    = rd_q;
            wb_data_d    = alu_c;
            ovf_set      = code_ovf && alu_overflow;
          end else begin
            illegal_sticky_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A set on the same edge as a clear takes priority
    ovf_sticky_d = ovf_set ? 1'b1 : (ovf_clear ? 1'b0 : ovf_sticky_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= 4'd0;
      alu_a_q          <= '0;
      alu_b_q          <= '0;
      alu_code_q       <= 5'd0;
      rd_q             <= 3'd0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      wb_valid_q       <= 1'b0;
      wb_addr_q        <= 3'd0;
      wb_data_q        <= '0;
      ovf_sticky_q     <= 1'b0;
      illegal_sticky_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      alu_a_q          <= alu_a_d;
      alu_b_q          <= alu_b_d;
      alu_code_q       <= alu_code_d;
      rd_q             <= rd_d;
      regs_q           <= regs_d;
      wb_valid_q       <= wb_valid_d;
      wb_addr_q        <= wb_addr_d;
      wb_data_q        <= wb_data_d;
      ovf_sticky_q     <= ovf_sticky_d;
      illegal_sticky_q <= illegal_sticky_d;
    end
  end

  assign instr_ready    = (state_q == IDLE) && !rst;
  assign busy           = (state_q != IDLE);
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_code       = alu_code_q;
  assign wb_valid       = wb_valid_q;
  assign wb_addr        = wb_addr_q;
  assign wb_data        = wb_data_q;
  assign ovf_sticky     = ovf_sticky_q;
  assign illegal_sticky = illegal_sticky_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl; a behavioural ALU answers the
// controller and a negedge monitor checks every writeback against the queue.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_code;
  logic        alu_overflow;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ovf_sticky, ovf_clear, illegal_sticky, busy;
  logic        force_ovf;

  int errors = 0;
  int checks = 0;
  logic [18:0] exp_q [$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_LAT(2), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
    .alu_c(alu_c), .alu_overflow(alu_overflow), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .ovf_sticky(ovf_sticky),
    .ovf_clear(ovf_clear), .illegal_sticky(illegal_sticky), .busy(busy)
  );

  // Stand-in ALU: 0 add, 1 move A, 16 shift left, anything else xor
  always_comb begin
    alu_c        = alu_a ^ alu_b;
    alu_overflow = force_ovf;
    case (alu_code)
      5'd0: begin
        alu_c        = alu_a + alu_b;
        alu_overflow = force_ovf || ((alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]));
      end
      5'd1:  alu_c = alu_a;
      5'd16: alu_c = alu_a << alu_b[3:0];
      default: alu_c = alu_a ^ alu_b;
    endcase
  end

  always @(negedge clk) begin
    if (wb_valid) begin
      logic [18:0] exp_v;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_wb: got addr=%0d data=%h, required no writeback", wb_addr, wb_data);
      end else begin
        exp_v = exp_q.pop_front();
        if ({wb_addr, wb_data} !== exp_v) begin
          errors++;
          $display("[TB] FAIL wb: got addr=%0d data=%h, required addr=%0d data=%h",
                   wb_addr, wb_data, exp_v[18:16], exp_v[15:0]);
        end
      end
    end
  end

  function automatic logic [15:0] mk(input logic [4:0] code, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic imm);
    return {code, rd, rs1, rs2, imm, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got instr_ready=0, required 1 within 50 cycles");
    end
  endtask

  // Offers one instruction and returns just after its accept edge
  task automatic applyStimulus(input logic [15:0] ins);
    waitReady();
    instr_valid = 1'b1;
    instr       = ins;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic cfgWrite(input logic [2:0] a, input logic [15:0] d);
    waitReady();
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic moveCheck(input logic [2:0] rs, input logic [2:0] rd, input logic [15:0] exp);
    exp_q.push_back({rd, exp});
    applyStimulus(mk(5'd1, rd, rs, 3'd0, 1'b0));
    waitReady();
  endtask

  initial begin
    int n;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; cfg_we = 1'b0; cfg_addr = 3'd0;
    cfg_wdata = 16'h0; ovf_clear = 1'b0; force_ovf = 1'b0;
    tick(); tick();
    checkOutput("reset_ready", {15'b0, instr_ready}, 16'h0);
    checkOutput("reset_busy", {15'b0, busy}, 16'h0);
    checkOutput("reset_flags", {14'b0, ovf_sticky, illegal_sticky}, 16'h0);
    checkOutput("reset_alu_a", alu_a, 16'h0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", {15'b0, instr_ready}, 16'h1);

    // Signed-add overflow into R3
    cfgWrite(3'd1, 16'h7FFF);
    cfgWrite(3'd2, 16'h0001);
    exp_q.push_back({3'd3, 16'h8000});
    applyStimulus(16'h0328);
    for (int i = 0; i < 2; i++) begin
      checkOutput("add_alu_a", alu_a, 16'h7FFF);
      checkOutput("add_alu_b", alu_b, 16'h0001);
      checkOutput("add_alu_code", {11'b0, alu_code}, 16'h0);
      tick();
    end
    waitReady();
    checkOutput("add_ovf_sticky", {15'b0, ovf_sticky}, 16'h1);
    moveCheck(3'd3, 3'd7, 16'h8000);

    // Immediate shift; overflow from a non-arithmetic code must be ignored
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    checkOutput("ovf_cleared", {15'b0, ovf_sticky}, 16'h0);
    cfgWrite(3'd3, 16'h00F0);
    force_ovf = 1'b1;
    exp_q.push_back({3'd4, 16'h0F00});
    applyStimulus(16'h8472);
    checkOutput("shift_alu_b", alu_b, 16'h0004);
    waitReady();
    force_ovf = 1'b0;
    checkOutput("shift_ovf_unchanged", {15'b0, ovf_sticky}, 16'h0);
    moveCheck(3'd4, 3'd7, 16'h0F00);

    // Illegal opcode: no writeback, sticky flag, 4-edge turnaround
    checkOutput("illegal_before", {15'b0, illegal_sticky}, 16'h0);
    applyStimulus(16'h3124);
    n = 1;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("illegal_turnaround", 16'(n), 16'd4);
    checkOutput("illegal_sticky", {15'b0, illegal_sticky}, 16'h1);
    moveCheck(3'd1, 3'd0, 16'h7FFF);

    // Back-to-back adds with a clear colliding with the second set
    exp_q.push_back({3'd5, 16'h8000});
    exp_q.push_back({3'd6, 16'h8000});
    waitReady();
    instr_valid = 1'b1; instr = 16'h0528;
    tick();
    instr = 16'h0644;
    tick();
    checkOutput("b2b_ready_t1", {15'b0, instr_ready}, 16'h0);
    tick();
    checkOutput("b2b_ready_t2", {15'b0, instr_ready}, 16'h0);
    checkOutput("b2b_ovf_first", {15'b0, ovf_sticky}, 16'h1);
    tick();
    checkOutput("b2b_ready_t3", {15'b0, instr_ready}, 16'h1);
    tick();
    instr_valid = 1'b0;
    checkOutput("b2b_second_accepted", {15'b0, busy}, 16'h1);
    checkOutput("b2b_second_alu_a", alu_a, 16'h0001);
    ovf_clear = 1'b1; tick();
    checkOutput("b2b_ovf_cleared", {15'b0, ovf_sticky}, 16'h0);
    tick();
    ovf_clear = 1'b0;
    checkOutput("b2b_set_wins", {15'b0, ovf_sticky}, 16'h1);
    waitReady();

    // Reset one cycle into EXEC abandons the instruction and clears everything
    applyStimulus(16'h0528);
    rst = 1'b1;
    tick();
    checkOutput("rst_ready_low", {15'b0, instr_ready}, 16'h0);
    checkOutput("rst_busy", {15'b0, busy}, 16'h0);
    rst = 1'b0;
    #1;
    checkOutput("rst_ready_after", {15'b0, instr_ready}, 16'h1);
    checkOutput("rst_flags", {14'b0, ovf_sticky, illegal_sticky}, 16'h0);
    for (int i = 0; i < 8; i++) moveCheck(3'(i), 3'(i + 1), 16'h0);

    // cfg write on the accept edge is not seen; cfg during EXEC is ignored
    cfgWrite(3'd1, 16'h0005);
    waitReady();
    exp_q.push_back({3'd2, 16'h0005});
    instr_valid = 1'b1; instr = mk(5'd1, 3'd2, 3'd1, 3'd0, 1'b0);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 16'h1234;
    tick();
    instr_valid = 1'b0;
    cfg_addr = 3'd1; cfg_wdata = 16'hBEEF;
    checkOutput("cfg_same_edge_alu_a", alu_a, 16'h0005);
    tick();
    cfg_we = 1'b0;
    waitReady();
    moveCheck(3'd1, 3'd3, 16'h1234);

    tick(); tick();
    checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
